// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic edge feeder: controller state
// encoding, PE pipeline depth and the flush length helper.
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Register stages inside one PE: a_reg, DSP, dsp_out_reg, c_out.
    localparam int PE_PIPE_DEPTH = 4;

    function automatic int flush_len(input int lanes, input int flush_extra);
        return (lanes - 1) + flush_extra;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Valid/ready operand stream into the feeder: one vector beat per transfer,
// lane i in data[i*data_width +: data_width], last marks the final beat of a tile.
interface systolic_skew_feeder_if #(
    parameter int data_width = 8,
    parameter int lanes      = 2
);
    logic                          valid;
    logic                          ready;
    logic [lanes*data_width-1:0]   data;
    logic                          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register for one array lane; it advances only when shift
// is high so a stalled array and its skew stay aligned.
module skew_delay_line #(
    parameter int data_width = 8,
    parameter int depth      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift,
    input  logic [data_width-1:0] d,
    output logic [data_width-1:0] q
);

    logic [data_width-1:0] r_pipe [depth];

    // Delay chain: shift on step, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (shift) begin
            r_pipe[0] <= d;
            for (int i = 1; i < depth; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                r_pipe[i] <= r_pipe[i];
            end
        end
    end

    assign q = r_pipe[depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Array-edge feeder: skews lane i of each accepted beat by i extra steps,
// drives the shared PE enable and zero-fills the array at the end of a tile.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int data_width  = 8,
    parameter int lanes       = 2,
    parameter int flush_extra = PE_PIPE_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    systolic_skew_feeder_if.slave       s_in,
    output logic [lanes*data_width-1:0] o_edge_data,
    output logic                        o_pe_en,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int FLUSH_LEN = flush_len(lanes, flush_extra);
    localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

    feeder_state_e              r_state;
    feeder_state_e              w_state_nxt;
    logic [CNT_W-1:0]           r_flush_cnt;
    logic                       w_ready;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_in_flush;
    logic                       w_accept;
    logic                       w_step;
    logic                       w_flush_end;
    logic [lanes*data_width-1:0] w_chain_in;
    logic [lanes*data_width-1:0] w_edge;

    assign w_accept    = s_in.valid & w_ready;
    assign w_step      = w_accept | w_in_flush;
    assign w_flush_end = w_in_flush && (r_flush_cnt == CNT_W'(FLUSH_LEN - 1));
    // Zero-fill while flushing; data only enters the chains on an accept.
    assign w_chain_in  = w_accept ? s_in.data : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = s_in.last ? ST_FLUSH : ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_accept && s_in.last) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (w_flush_end) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        w_ready    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_in_flush = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_STREAM: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            ST_FLUSH: begin
                w_busy     = 1'b1;
                w_in_flush = 1'b1;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // Flush beat counter: zero outside FLUSH, so entry always starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_in_flush && (w_state_nxt == ST_FLUSH)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end else begin
            r_flush_cnt <= '0;
        end
    end

    for (genvar g = 0; g < lanes; g++) begin : g_lane
        skew_delay_line #(
            .data_width (data_width),
            .depth      (g + 1)
        ) u_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .shift (w_step),
            .d     (w_chain_in[g*data_width +: data_width]),
            .q     (w_edge[g*data_width +: data_width])
        );
    end

    assign s_in.ready  = w_ready;
    assign o_edge_data = w_edge;
    assign o_pe_en     = w_step;
    assign o_busy      = w_busy;
    assign o_done      = w_done;

endmodule
